// File: rtl/diff_bram_arbiter.sv
// Single-port difference BRAM shared between a never-stalled capture path (A)
// and a low-priority req/gnt reader (B) served only in A-idle cycles.
module diff_bram_arbiter #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 8,
  parameter int FRAME_SIZE = 76800,
  parameter int RD_LATENCY = 1,
  parameter int STARVE_LIM = 1023
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              a_en,
  input  logic              a_wren,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_addr,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_err,
  output logic              b_starved,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  input  logic [DATA_W-1:0] bram_dout
);

  localparam int CNT_W = $clog2(STARVE_LIM + 1);
  localparam logic [CNT_W-1:0]  CNT_LIM   = CNT_W'(STARVE_LIM);
  localparam logic [ADDR_W:0]   FRAME_LIM = (ADDR_W+1)'(FRAME_SIZE);

  typedef enum logic [1:0] {IDLE, PEND, RDWAIT} state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       wait_cnt_q, wait_cnt_d;
  logic                   starved_q, starved_d;
  logic [RD_LATENCY-1:0]  vld_pipe_q, vld_pipe_d;
  logic [RD_LATENCY-1:0]  err_pipe_q, err_pipe_d;
  logic                   rvalid_q, err_q;
  logic [DATA_W-1:0]      rdata_q;
  logic                   b_in_range, capture, cap_err;

  assign b_in_range = ({1'b0, b_addr} < FRAME_LIM);
  assign capture    = vld_pipe_q[RD_LATENCY-1];
  assign cap_err    = err_pipe_q[RD_LATENCY-1];
  // Gated by reset so nothing is accepted while the block is held in reset.
  assign b_gnt      = resetn & b_req & ~a_en & (state_q != RDWAIT);

  assign a_rdata    = bram_dout;
  assign b_rvalid   = rvalid_q;
  assign b_rdata    = rdata_q;
  assign b_err      = err_q;
  assign b_starved  = starved_q;

  always_comb begin
    bram_en   = 1'b0;
    bram_we   = 1'b0;
    bram_addr = '0;
    bram_din  = '0;
    if (a_en) begin
      bram_en   = 1'b1;
      bram_we   = a_wren;
      bram_addr = a_addr;
      bram_din  = a_wdata;
    end else if (b_gnt && b_in_range) begin
      bram_en   = 1'b1;
      bram_addr = b_addr;
    end
  end

  // Latency tracker: the grant bit walks to the slot where bram_dout belongs to B.
  always_comb begin
    vld_pipe_d    = '0;
    err_pipe_d    = '0;
    vld_pipe_d[0] = b_gnt;
    err_pipe_d[0] = b_gnt & ~b_in_range;
    for (int i = 1; i < RD_LATENCY; i++) begin
      vld_pipe_d[i] = vld_pipe_q[i-1];
      err_pipe_d[i] = err_pipe_q[i-1];
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      IDLE: begin
        wait_cnt_d = '0;
        if (b_req) state_d = b_gnt ? RDWAIT : PEND;
      end
      PEND: begin
        if (!b_req) begin
          state_d    = IDLE;
          wait_cnt_d = '0;
        end else if (b_gnt) begin
          state_d    = RDWAIT;
          wait_cnt_d = '0;
        end else if (wait_cnt_q != CNT_LIM) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      RDWAIT: if (capture) state_d = IDLE;
      default: begin
        state_d    = IDLE;
        wait_cnt_d = '0;
      end
    endcase
    starved_d = starved_q | (wait_cnt_d == CNT_LIM);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      starved_q  <= 1'b0;
      vld_pipe_q <= '0;
      err_pipe_q <= '0;
      rvalid_q   <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      starved_q  <= starved_d;
      vld_pipe_q <= vld_pipe_d;
      err_pipe_q <= err_pipe_d;
      rvalid_q   <= capture;
      err_q      <= capture & cap_err;
      if (capture) rdata_q <= cap_err ? '0 : bram_dout;
    end
  end

endmodule

// File: tb/tb_diff_bram_arbiter.sv
// Directed bench for diff_bram_arbiter with a 1-cycle registered BRAM model.
module tb_diff_bram_arbiter;

  logic        clk;
  logic        resetn;
  logic        a_en, a_wren;
  logic [16:0] a_addr;
  logic [7:0]  a_wdata, a_rdata;
  logic        b_req;
  logic [16:0] b_addr;
  logic        b_gnt, b_rvalid, b_err, b_starved;
  logic [7:0]  b_rdata;
  logic        bram_en, bram_we;
  logic [16:0] bram_addr;
  logic [7:0]  bram_din, bram_dout;

  logic [7:0]  mem [0:131071];
  int          pass_cnt, fail_cnt, total, gcnt;

  diff_bram_arbiter dut (
    .clk(clk), .resetn(resetn),
    .a_en(a_en), .a_wren(a_wren), .a_addr(a_addr), .a_wdata(a_wdata), .a_rdata(a_rdata),
    .b_req(b_req), .b_addr(b_addr), .b_gnt(b_gnt), .b_rvalid(b_rvalid),
    .b_rdata(b_rdata), .b_err(b_err), .b_starved(b_starved),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_din(bram_din), .bram_dout(bram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_we) mem[bram_addr] <= bram_din;
      else         bram_dout      <= mem[bram_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Grant in the current cycle, rvalid two cycles later (RD_LATENCY=1).
  task automatic rd_b(input string tag, input logic [16:0] addr,
                      input logic [7:0] exp_data, input logic exp_err, input logic exp_en);
    b_req = 1'b1; b_addr = addr; a_en = 1'b0; a_wren = 1'b0;
    #1;
    chk({tag, "_gnt"}, 32'(b_gnt), 32'd1);
    chk({tag, "_bram_en"}, 32'(bram_en), 32'(exp_en));
    tick();
    b_req = 1'b0;
    #1;
    chk({tag, "_rvalid_early"}, 32'(b_rvalid), 32'd0);
    tick();
    #1;
    chk({tag, "_rvalid"}, 32'(b_rvalid), 32'd1);
    chk({tag, "_rdata"}, 32'(b_rdata), 32'(exp_data));
    chk({tag, "_err"}, 32'(b_err), 32'(exp_err));
    tick();
    #1;
    chk({tag, "_rvalid_pulse"}, 32'(b_rvalid), 32'd0);
  endtask

  initial begin
    pass_cnt = 0; fail_cnt = 0; total = 0; gcnt = 0;
    for (int i = 0; i < 131072; i++) mem[i] = 8'(i) ^ 8'h3C;
    mem[100]  = 8'h5A;
    bram_dout = 8'h00;
    resetn = 1'b0; a_en = 1'b0; a_wren = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b1; b_addr = 17'd5;

    // Reset held with a pending request
    tick(); tick();
    #1;
    chk("rst_gnt", 32'(b_gnt), 32'd0);
    chk("rst_rvalid", 32'(b_rvalid), 32'd0);
    chk("rst_rdata", 32'(b_rdata), 32'd0);
    chk("rst_err", 32'(b_err), 32'd0);
    chk("rst_starved", 32'(b_starved), 32'd0);
    tick();
    resetn = 1'b1;
    rd_b("rel", 17'd5, 8'h39, 1'b0, 1'b1);

    // Idle read
    tick();
    rd_b("idle", 17'd100, 8'h5A, 1'b0, 1'b1);

    // Contention: A writes 5 cycles, B granted on the 6th
    for (int i = 0; i < 5; i++) begin
      a_en = 1'b1; a_wren = 1'b1; a_addr = 17'(200 + i); a_wdata = 8'(8'h10 + i);
      b_req = 1'b1; b_addr = 17'd100;
      #1;
      chk("cont_gnt_blocked", 32'(b_gnt), 32'd0);
      chk("cont_bram_addr", 32'(bram_addr), 32'(200 + i));
      tick();
    end
    rd_b("cont", 17'd100, 8'h5A, 1'b0, 1'b1);
    a_en = 1'b1; a_wren = 1'b0; a_addr = 17'd202;
    tick();
    a_en = 1'b0;
    #1;
    chk("cont_a_readback", 32'(a_rdata), 32'h12);

    // Interleave: A overwrites addr 100 while B read is in flight
    tick();
    b_req = 1'b1; b_addr = 17'd100;
    #1;
    chk("ilv_gnt", 32'(b_gnt), 32'd1);
    tick();
    b_req = 1'b0; a_en = 1'b1; a_wren = 1'b1; a_addr = 17'd100; a_wdata = 8'hC3;
    #1;
    chk("ilv_a_we", 32'(bram_we), 32'd1);
    tick();
    a_wren = 1'b0;
    #1;
    chk("ilv_rvalid", 32'(b_rvalid), 32'd1);
    chk("ilv_old_data", 32'(b_rdata), 32'h5A);
    tick();
    a_en = 1'b0;
    #1;
    chk("ilv_a_new", 32'(a_rdata), 32'hC3);

    // Out-of-range address
    tick();
    rd_b("oor", 17'd76800, 8'h00, 1'b1, 1'b0);

    // Starvation, then reset during RDWAIT
    a_en = 1'b1; a_wren = 1'b0; a_addr = 17'd0; b_req = 1'b1; b_addr = 17'd7;
    for (int i = 0; i < 1100; i++) begin
      #1;
      if (b_gnt) gcnt++;
      if (i == 1000) chk("starve_early", 32'(b_starved), 32'd0);
      tick();
    end
    chk("starve_no_gnt", 32'(gcnt), 32'd0);
    chk("starve_set", 32'(b_starved), 32'd1);
    a_en = 1'b0;
    #1;
    chk("starve_gnt", 32'(b_gnt), 32'd1);
    tick();
    b_req = 1'b0;
    chk("starve_sticky", 32'(b_starved), 32'd1);
    resetn = 1'b0;
    #1;
    chk("abort_starved_clr", 32'(b_starved), 32'd0);
    tick();
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("abort_no_rvalid", 32'(b_rvalid), 32'd0);
      tick();
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
